// File: rtl/cam_pkg.sv
// Shared types for the CAM command controller: request opcodes and FSM states.
package cam_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_SEARCH  = 2'b10,
        OP_ILLEGAL = 2'b11
    } cam_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_SR,
        S_RESP
    } cam_state_e;

    localparam int unsigned CAM_WIDTH      = 32;
    localparam int unsigned CAM_ADDR_WIDTH = 5;

    typedef struct packed {
        logic [CAM_WIDTH-1:0]      data;
        logic [CAM_ADDR_WIDTH-1:0] index;
        logic                      hit;
        logic                      multi;
        logic                      err;
    } cam_rsp_t;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder over the occupancy-masked match vector.
module cam_prio_enc #(
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic [DEPTH-1:0]      hits,
    output logic [ADDR_WIDTH-1:0] index,
    output logic                  any,
    output logic                  multi
);

    always_comb begin
        index = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int unsigned i = DEPTH; i > 0; i--) begin
            if (hits[i-1]) index = ADDR_WIDTH'(i - 1);
        end
    end

    assign any   = |hits;
    assign multi = |(hits & (hits - DEPTH'(1)));

endmodule

// File: rtl/cam_ctrl.sv
// Command-side CAM controller: serialises read/write/search requests onto the
// word array's enables and returns one registered response per request.
module cam_ctrl
    import cam_pkg::*;
#(
    parameter int unsigned WIDTH      = CAM_WIDTH,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_WIDTH = CAM_ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [1:0]             req_op_i,
    input  logic [ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [WIDTH-1:0]       req_data_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [WIDTH-1:0]       rsp_data_o,
    output logic [ADDR_WIDTH-1:0]  rsp_index_o,
    output logic                   rsp_hit_o,
    output logic                   rsp_multi_o,
    output logic                   rsp_err_o,
    output logic [DEPTH-1:0]       cam_read_enable_o,
    output logic [DEPTH-1:0]       cam_write_enable_o,
    output logic                   cam_search_enable_o,
    output logic [WIDTH-1:0]       cam_write_data_o,
    output logic [WIDTH-1:0]       cam_search_data_o,
    input  logic [DEPTH*WIDTH-1:0] cam_data_i,
    input  logic [DEPTH-1:0]       cam_search_i
);

    cam_state_e            state;
    cam_state_e            state_next;
    cam_op_e               req_op;
    logic                  req_legal;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WIDTH-1:0]      data_q;
    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      addr_onehot;
    logic [DEPTH-1:0]      hits;
    logic [ADDR_WIDTH-1:0] hit_index;
    logic                  hit_any;
    logic                  hit_multi;
    cam_rsp_t              rsp_q;

    assign req_op      = cam_op_e'(req_op_i);
    assign req_legal   = (req_op != OP_ILLEGAL) && (32'(req_addr_i) < DEPTH);
    assign addr_onehot = DEPTH'(1) << addr_q;
    assign hits        = cam_search_i & valid_q;

    cam_prio_enc #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_prio_enc (
        .hits  (hits),
        .index (hit_index),
        .any   (hit_any),
        .multi (hit_multi)
    );

    always_comb begin
        state_next          = state;
        req_ready_o         = 1'b0;
        rsp_valid_o         = 1'b0;
        cam_read_enable_o   = '0;
        cam_write_enable_o  = '0;
        cam_search_enable_o = 1'b0;
        cam_write_data_o    = '0;
        cam_search_data_o   = '0;
        case (state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    if (!req_legal)               state_next = S_RESP;
                    else if (req_op == OP_READ)   state_next = S_RD;
                    else if (req_op == OP_WRITE)  state_next = S_WR;
                    else                          state_next = S_SR;
                end
            end
            S_RD: begin
                cam_read_enable_o = addr_onehot;
                state_next        = S_RESP;
            end
            S_WR: begin
                cam_write_enable_o = addr_onehot;
                cam_write_data_o   = data_q;
                state_next         = S_RESP;
            end
            S_SR: begin
                cam_search_enable_o = 1'b1;
                cam_search_data_o   = data_q;
                state_next          = S_RESP;
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= '0;
            rsp_q   <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        addr_q <= req_addr_i;
                        data_q <= req_data_i;
                        if (!req_legal) begin
                            rsp_q <= '{data: '0, index: req_addr_i, hit: 1'b0,
                                       multi: 1'b0, err: 1'b1};
                        end
                    end
                end
                S_WR: begin
                    valid_q <= valid_q | addr_onehot;
                    rsp_q   <= '{data: data_q, index: addr_q, hit: 1'b0,
                                 multi: 1'b0, err: 1'b0};
                end
                S_RD: begin
                    rsp_q.index <= addr_q;
                    rsp_q.hit   <= 1'b0;
                    rsp_q.multi <= 1'b0;
                    if (|(valid_q & addr_onehot)) begin
                        rsp_q.data <= cam_data_i[WIDTH*32'(addr_q) +: WIDTH];
                        rsp_q.err  <= 1'b0;
                    end else begin
                        rsp_q.data <= '0;
                        rsp_q.err  <= 1'b1;
                    end
                end
                S_SR: begin
                    rsp_q <= '{data: data_q, index: hit_index, hit: hit_any,
                               multi: hit_multi, err: 1'b0};
                end
                default: ;
            endcase
        end
    end

    assign rsp_data_o  = rsp_q.data;
    assign rsp_index_o = rsp_q.index;
    assign rsp_hit_o   = rsp_q.hit;
    assign rsp_multi_o = rsp_q.multi;
    assign rsp_err_o   = rsp_q.err;

endmodule

// File: tb/tb_cam_ctrl.sv
// Bench for cam_ctrl: a behavioural word array plus a transaction-level model
// checked every cycle, with directed scenarios and randomized traffic.
module tb_cam_ctrl;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;

    logic          clk;
    logic          reset;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [1:0]    req_op_i;
    logic [AW-1:0] req_addr_i;
    logic [W-1:0]  req_data_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [W-1:0]  rsp_data_o;
    logic [AW-1:0] rsp_index_o;
    logic          rsp_hit_o;
    logic          rsp_multi_o;
    logic          rsp_err_o;
    logic [D-1:0]  cam_read_enable_o;
    logic [D-1:0]  cam_write_enable_o;
    logic          cam_search_enable_o;
    logic [W-1:0]  cam_write_data_o;
    logic [W-1:0]  cam_search_data_o;
    logic [D*W-1:0] cam_data_i;
    logic [D-1:0]  cam_search_i;

    cam_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .req_op_i            (req_op_i),
        .req_addr_i          (req_addr_i),
        .req_data_i          (req_data_i),
        .rsp_valid_o         (rsp_valid_o),
        .rsp_ready_i         (rsp_ready_i),
        .rsp_data_o          (rsp_data_o),
        .rsp_index_o         (rsp_index_o),
        .rsp_hit_o           (rsp_hit_o),
        .rsp_multi_o         (rsp_multi_o),
        .rsp_err_o           (rsp_err_o),
        .cam_read_enable_o   (cam_read_enable_o),
        .cam_write_enable_o  (cam_write_enable_o),
        .cam_search_enable_o (cam_search_enable_o),
        .cam_write_data_o    (cam_write_data_o),
        .cam_search_data_o   (cam_search_data_o),
        .cam_data_i          (cam_data_i),
        .cam_search_i        (cam_search_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Word array: random power-up contents, written by the DUT's enables.
    logic [W-1:0] ram [D];
    logic         scramble;
    logic [D-1:0] noise;
    logic [D-1:0] written;
    logic [W-1:0] mem_m [D];

    always @(posedge clk) begin
        for (int i = 0; i < D; i++) begin
            if (scramble) ram[i] <= $urandom;
            else if (cam_write_enable_o[i]) ram[i] <= cam_write_data_o;
        end
    end

    // Spurious match flags only on words the model knows are unwritten.
    always_comb begin
        for (int i = 0; i < D; i++) begin
            cam_data_i[W*i +: W] = ram[i];
            cam_search_i[i] = (ram[i] == cam_search_data_o) | (noise[i] & ~written[i]);
        end
    end

    // Transaction-level reference model and per-cycle comparison.
    bit            busy = 1'b0, shrt, prev_rdy = 1'b0, prev_rv = 1'b0, wen_seen = 1'b0;
    int            k;
    logic [1:0]    e_op;
    logic [AW-1:0] e_addr, e_index;
    logic [W-1:0]  e_data, e_key;
    logic          e_hit, e_multi, e_err, exp_rv, en_phase;
    logic [D-1:0]  e_onehot;
    int            cnt;

    always @(negedge clk) begin
        wen_seen = wen_seen | (|cam_write_enable_o);
        if (reset) begin
            busy    = 1'b0;
            written = '0;
            check("reset_req_ready", req_ready_o, 1'b1);
            check("reset_rsp_valid", rsp_valid_o, 1'b0);
            check("reset_enables", {cam_read_enable_o, cam_write_enable_o}, '0);
            check("reset_buses", {cam_search_enable_o, cam_write_data_o, cam_search_data_o[W-1:1]}, '0);
            check("reset_rsp", {rsp_data_o, rsp_index_o, rsp_hit_o, rsp_multi_o, rsp_err_o}, '0);
        end else begin
            if (!busy && prev_rdy && req_valid_i) begin
                busy = 1'b1; k = 1; shrt = 1'b0;
                e_op = req_op_i; e_addr = req_addr_i; e_key = req_data_i;
                e_index = req_addr_i; e_hit = 1'b0; e_multi = 1'b0; e_err = 1'b0;
                if (req_op_i == 2'b11 || int'(req_addr_i) >= D) begin
                    shrt = 1'b1; e_err = 1'b1; e_data = '0;
                end else if (req_op_i == 2'b00) begin
                    e_err  = !written[req_addr_i];
                    e_data = written[req_addr_i] ? mem_m[req_addr_i] : '0;
                end else if (req_op_i == 2'b01) begin
                    e_data = req_data_i;
                    written[req_addr_i] = 1'b1;
                    mem_m[req_addr_i] = req_data_i;
                end else begin
                    e_data = req_data_i; e_index = '0; cnt = 0;
                    for (int i = D - 1; i >= 0; i--) begin
                        if (written[i] && mem_m[i] == req_data_i) begin
                            cnt++; e_index = AW'(i);
                        end
                    end
                    e_hit = (cnt > 0); e_multi = (cnt > 1);
                end
            end else if (busy && prev_rv && rsp_ready_i) begin
                busy = 1'b0;
            end else if (busy) begin
                k++;
            end

            if (busy) begin
                exp_rv   = shrt || (k >= 2);
                en_phase = !shrt && (k == 1);
                e_onehot = D'(1) << e_addr;
                check("req_ready_busy", req_ready_o, 1'b0);
                check("rsp_valid", rsp_valid_o, exp_rv);
                check("read_en", cam_read_enable_o, (en_phase && e_op == 2'b00) ? e_onehot : '0);
                check("write_en", cam_write_enable_o, (en_phase && e_op == 2'b01) ? e_onehot : '0);
                check("write_data", cam_write_data_o, (en_phase && e_op == 2'b01) ? e_key : '0);
                check("search_en", {cam_search_enable_o, cam_search_data_o},
                      (en_phase && e_op == 2'b10) ? {1'b1, e_key} : '0);
                if (exp_rv) begin
                    check("rsp_data", rsp_data_o, e_data);
                    check("rsp_index", rsp_index_o, e_index);
                    check("rsp_flags", {rsp_hit_o, rsp_multi_o, rsp_err_o}, {e_hit, e_multi, e_err});
                end
            end else begin
                check("idle_req_ready", req_ready_o, 1'b1);
                check("idle_rsp_valid", rsp_valid_o, 1'b0);
                check("idle_enables", {cam_read_enable_o, cam_write_enable_o, cam_search_enable_o}, '0);
                check("idle_buses", {cam_write_data_o, cam_search_data_o}, '0);
            end
        end
        prev_rdy = req_ready_o;
        prev_rv  = rsp_valid_o;
    end

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    task automatic transact(input logic [1:0] op, input logic [AW-1:0] a, input logic [W-1:0] d,
                            input int stall, output logic [W-1:0] r_data,
                            output logic [AW-1:0] r_idx, output logic [2:0] r_flags);
        int n;
        @(negedge clk); #1;
        req_valid_i = 1'b1; req_op_i = op; req_addr_i = a; req_data_i = d;
        n = 0;
        while (!req_ready_o && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) timeout("req_accept");
        @(negedge clk); #1;
        req_valid_i = 1'b0;
        n = 0;
        while (!rsp_valid_o && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) timeout("rsp_valid_wait");
        repeat (stall) begin @(negedge clk); #1; end
        r_data  = rsp_data_o;
        r_idx   = rsp_index_o;
        r_flags = {rsp_hit_o, rsp_multi_o, rsp_err_o};
        rsp_ready_i = 1'b1;
        @(negedge clk); #1;
        rsp_ready_i = 1'b0;
    endtask

    logic [W-1:0]  r_data;
    logic [AW-1:0] r_idx;
    logic [2:0]    r_flags;
    logic [W-1:0]  pool [4];

    initial begin
        reset = 1'b1; scramble = 1'b1; noise = '0;
        req_valid_i = 1'b0; req_op_i = '0; req_addr_i = '0; req_data_i = '0; rsp_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        #1; scramble = 1'b0;
        @(negedge clk); #1; reset = 1'b0;

        // Cleared words must not hit even when the array flags every word.
        noise = '1;
        transact(2'b10, '0, 32'h0, 0, r_data, r_idx, r_flags);
        check("t1_flags", r_flags, 3'b000);
        check("t1_no_write", wen_seen, 1'b0);
        noise = '0;

        transact(2'b01, 5'd0, 32'hF0F0F0F0, 0, r_data, r_idx, r_flags);
        transact(2'b00, 5'd0, 32'h0, 1, r_data, r_idx, r_flags);
        check("t2_read_data", r_data, 32'hF0F0F0F0);
        check("t2_read_idx_err", {r_idx, r_flags[0]}, 6'd0);

        transact(2'b01, 5'd5, 32'h80000000, 0, r_data, r_idx, r_flags);
        transact(2'b01, 5'd9, 32'h80000000, 2, r_data, r_idx, r_flags);
        transact(2'b10, 5'd0, 32'h80000000, 0, r_data, r_idx, r_flags);
        check("t3_index", r_idx, 5'd5);
        check("t3_flags", r_flags, 3'b110);

        transact(2'b00, 5'd7, 32'h0, 0, r_data, r_idx, r_flags);
        check("t4_unwritten", {r_data, r_flags}, {32'h0, 3'b001});
        transact(2'b11, 5'd3, 32'h1234, 0, r_data, r_idx, r_flags);
        check("t4_illegal_err", r_flags[0], 1'b1);

        transact(2'b00, 5'd9, 32'h0, 10, r_data, r_idx, r_flags);
        check("t5_stalled_read", {r_data, r_flags}, {32'h80000000, 3'b000});

        // Reset while the write to word 31 is on the array enables.
        @(negedge clk); #1;
        req_valid_i = 1'b1; req_op_i = 2'b01; req_addr_i = 5'd31; req_data_i = 32'hCAFEBABE;
        @(negedge clk); #1;
        req_valid_i = 1'b0;
        check("t6_in_wr", cam_write_enable_o, 32'h80000000);
        reset = 1'b1;
        @(negedge clk);
        check("t6_wen_dropped", cam_write_enable_o, '0);
        #1; reset = 1'b0;
        repeat (2) @(negedge clk);
        check("t6_no_rsp", rsp_valid_o, 1'b0);
        transact(2'b10, 5'd0, 32'hCAFEBABE, 0, r_data, r_idx, r_flags);
        check("t6_search_after_reset", r_flags, 3'b000);

        pool[0] = 32'hA5A5A5A5; pool[1] = 32'h0; pool[2] = 32'h12345678; pool[3] = 32'hFFFFFFFF;
        for (int t = 0; t < 300; t++) begin
            int sel;
            logic [1:0] op;
            logic [W-1:0] d;
            sel = $urandom_range(0, 9);
            op = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            d = ($urandom_range(0, 7) == 0) ? W'($urandom) : pool[$urandom_range(0, 3)];
            noise = D'($urandom);
            transact(op, AW'($urandom_range(0, D - 1)), d, $urandom_range(0, 3),
                     r_data, r_idx, r_flags);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
